// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, parity encodings and baud divider helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Rounded clocks-per-oversample-tick.
    function automatic int calc_div(input longint clk, input longint baud, input longint os);
        return int'((clk + (baud * os) / 2) / (baud * os));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running divider emitting a one-cycle tick every DIV clocks,
//               with a synchronous restart used to align to a start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_baud_tick: DIV must be at least 1");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == C_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver with majority vote,
//               false-start rejection, error flags and a valid/ready holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK_50M,
    input  logic                 RST,
    input  logic                 UART_RX,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int            DIV      = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int            SW       = $clog2(OVERSAMPLE);
    localparam int            BW       = $clog2(DATA_BITS);
    localparam logic [SW-1:0] C_S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] C_S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] C_S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] C_S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] C_STOP_L = BW'(STOP_BITS - 1);

    generate
        if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("uart_rx_param: OVERSAMPLE must be even and within 8..32");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
            $error("uart_rx_param: DATA_BITS must be within 5..9");
        end
        if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
            $error("uart_rx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    rx_state_e              state_q, state_d;
    logic                   sync1_q, rx_s_q, rx_p_q;
    logic [SW-1:0]          scnt_q, scnt_d;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic                   s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d, pout_q, pout_d, fout_q, fout_d, ovr_q, ovr_d;
    logic                   w_tick, w_restart, w_centre, w_wrap, w_vote, w_par_exp, w_complete;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk_i    (CLK_50M),
        .rst_i    (RST),
        .restart_i(w_restart),
        .tick_o   (w_tick)
    );

    assign w_centre  = w_tick && (scnt_q == C_S_HI);
    assign w_wrap    = w_tick && (scnt_q == C_S_LAST);
    assign w_vote    = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    assign w_par_exp = (PARITY == PAR_ODD) ? ~(^sh_q) : (^sh_q);

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        bcnt_d     = bcnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        sh_d       = sh_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        w_restart  = 1'b0;
        w_complete = 1'b0;

        if (w_tick && (state_q != ST_IDLE)) begin
            scnt_d = (scnt_q == C_S_LAST) ? '0 : scnt_q + SW'(1);
            if (scnt_q == C_S_LO) s0_d = rx_s_q;
            if (scnt_q == C_S_MID) s1_d = rx_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_p_q && !rx_s_q) begin
                    w_restart = 1'b1;
                    scnt_d    = '0;
                    bcnt_d    = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (w_centre && w_vote) begin
                    state_d = ST_IDLE;
                end else if (w_wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_centre) sh_d = {w_vote, sh_q[DATA_BITS-1:1]};
                if (w_wrap) begin
                    if (bcnt_q == C_B_LAST) begin
                        bcnt_d  = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_centre && (w_vote != w_par_exp)) perr_d = 1'b1;
                if (w_wrap) state_d = ST_STOP;
            end
            ST_STOP: begin
                // The last stop bit ends the frame at its centre so a following
                // start edge half a bit later is still seen from IDLE.
                if (w_centre) begin
                    if (!w_vote) ferr_d = 1'b1;
                    if (bcnt_q == C_STOP_L) begin
                        w_complete = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else if (w_wrap) begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pout_d  = pout_q;
        fout_d  = fout_q;
        ovr_d   = 1'b0;
        if (w_complete) begin
            if (!valid_q || rx_ready) begin
                data_d  = sh_q;
                pout_d  = perr_q;
                fout_d  = ferr_q | ~w_vote;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_p_q  <= 1'b1;
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pout_q  <= 1'b0;
            fout_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= UART_RX;
            rx_s_q  <= sync1_q;
            rx_p_q  <= rx_s_q;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pout_q  <= pout_d;
            fout_q  <= fout_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = pout_q;
    assign frame_err   = fout_q;
    assign overrun_err = ovr_q;
    assign rx_busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Directed bench for uart_rx_param in 8N1, 7E1 and 8N2 builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam real BIT_NS = 160.0;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] line;
    logic [2:0] rdy;

    logic [7:0] d0, d2;
    logic [6:0] d1;
    logic       v0, p0, f0, o0, b0;
    logic       v1, p1, f1, o1, b1;
    logic       v2, p2, f2, o2, b2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 0;

    int         xc0 = 0, vh0 = 0, oc0 = 0, xcyc0 = 0;
    logic [7:0] xd0 = '0;
    logic       xp0 = 1'b0, xf0 = 1'b0;
    int         xc1 = 0;
    logic [6:0] xd1 = '0;
    logic       xp1 = 1'b0, xf1 = 1'b0;
    int         xc2 = 0;
    logic [7:0] xd2 = '0;
    logic       xp2 = 1'b0, xf2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .CLK_50M(clk), .RST(rst), .UART_RX(line[0]), .rx_ready(rdy[0]),
        .rx_data(d0), .rx_valid(v0), .parity_err(p0), .frame_err(f0),
        .overrun_err(o0), .rx_busy(b0));

    uart_rx_param #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .CLK_50M(clk), .RST(rst), .UART_RX(line[1]), .rx_ready(rdy[1]),
        .rx_data(d1), .rx_valid(v1), .parity_err(p1), .frame_err(f1),
        .overrun_err(o1), .rx_busy(b1));

    uart_rx_param #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut2 (
        .CLK_50M(clk), .RST(rst), .UART_RX(line[2]), .rx_ready(rdy[2]),
        .rx_data(d2), .rx_valid(v2), .parity_err(p2), .frame_err(f2),
        .overrun_err(o2), .rx_busy(b2));

    // Record every accepted word, valid-high cycles and overrun pulses.
    always @(negedge clk) begin
        if (v0) vh0 <= vh0 + 1;
        if (o0) oc0 <= oc0 + 1;
        if (v0 && rdy[0]) begin
            xc0 <= xc0 + 1; xd0 <= d0; xp0 <= p0; xf0 <= f0; xcyc0 <= cyc;
        end
        if (v1 && rdy[1]) begin
            xc1 <= xc1 + 1; xd1 <= d1; xp1 <= p1; xf1 <= f1;
        end
        if (v2 && rdy[2]) begin
            xc2 <= xc2 + 1; xd2 <= d2; xp2 <= p2; xf2 <= f2;
        end
    end

    function automatic logic [15:0] mkframe(input logic [8:0] d, input int nd,
                                            input bit has_par, input logic pbit,
                                            input logic [1:0] stp);
        logic [15:0] f;
        int p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1;
        for (int i = 0; i < nd; i++) begin
            f[p] = d[i];
            p++;
        end
        if (has_par) begin
            f[p] = pbit;
            p++;
        end
        f[p]     = stp[0];
        f[p + 1] = stp[1];
        return f;
    endfunction

    task automatic send(input int k, input logic [15:0] f, input int n, input real bns);
        for (int i = 0; i < n; i++) begin
            line[k] = f[i];
            #(bns);
        end
        line[k] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({v0, p0, f0, o0, b0} !== 5'b0) begin
            errors++; $display("FAIL reset_flags0: got %b expected 00000", {v0, p0, f0, o0, b0});
        end
        checks++;
        if (d0 !== 8'h00) begin
            errors++; $display("FAIL reset_data0: got %h expected 00", d0);
        end
        checks++;
        if ({v1, p1, f1, o1, b1, d1} !== 12'h000) begin
            errors++; $display("FAIL reset_dut1: got %h expected 000", {v1, p1, f1, o1, b1, d1});
        end
        checks++;
        if ({v2, p2, f2, o2, b2, d2} !== 13'h0000) begin
            errors++; $display("FAIL reset_dut2: got %h expected 0000", {v2, p2, f2, o2, b2, d2});
        end
        rst = 1'b0;
        idle(8);
        checks++;
        if ({b0, b1, b2} !== 3'b000) begin
            errors++; $display("FAIL idle_busy: got %b expected 000", {b0, b1, b2});
        end
    endtask

    task automatic test_8n1;
        int s, c, h;
        c = xc0; h = vh0;
        @(posedge clk); #1;
        s = cyc;
        send(0, mkframe(9'h0A5, 8, 1'b0, 1'b0, 2'b11), 10, BIT_NS);
        idle(20);
        lat = xcyc0 - s;
        checks++;
        if (xc0 !== c + 1) begin
            errors++; $display("FAIL 8n1_count: got %0d expected %0d", xc0 - c, 1);
        end
        checks++;
        if (xd0 !== 8'hA5) begin
            errors++; $display("FAIL 8n1_data: got %h expected a5", xd0);
        end
        checks++;
        if ({xp0, xf0} !== 2'b00) begin
            errors++; $display("FAIL 8n1_flags: got %b expected 00", {xp0, xf0});
        end
        checks++;
        if (vh0 - h !== 1) begin
            errors++; $display("FAIL 8n1_valid_width: got %0d expected 1", vh0 - h);
        end
        // 9.5 bits = 152 clocks, plus sync, edge-detect and holding-register delay.
        checks++;
        if (lat < 149 || lat > 158) begin
            errors++; $display("FAIL 8n1_latency: got %0d expected 149..158", lat);
        end
    endtask

    task automatic test_parity;
        int c;
        c = xc1;
        @(posedge clk); #1;
        send(1, mkframe(9'h035, 7, 1'b1, 1'b0, 2'b11), 10, BIT_NS);
        idle(20);
        checks++;
        if (xd1 !== 7'h35 || xp1 !== 1'b0) begin
            errors++; $display("FAIL par_good: got data %h perr %b expected 35 0", xd1, xp1);
        end
        send(1, mkframe(9'h035, 7, 1'b1, 1'b1, 2'b11), 10, BIT_NS);
        idle(20);
        checks++;
        if (xc1 !== c + 2) begin
            errors++; $display("FAIL par_count: got %0d expected 2", xc1 - c);
        end
        checks++;
        if (xd1 !== 7'h35) begin
            errors++; $display("FAIL par_bad_data: got %h expected 35", xd1);
        end
        checks++;
        if ({xp1, xf1} !== 2'b10) begin
            errors++; $display("FAIL par_bad_flags: got %b expected 10", {xp1, xf1});
        end
    endtask

    task automatic test_stop;
        int c;
        c = xc2;
        @(posedge clk); #1;
        send(2, mkframe(9'h0C3, 8, 1'b0, 1'b0, 2'b11), 11, BIT_NS);
        idle(20);
        checks++;
        if (xd2 !== 8'hC3 || {xp2, xf2} !== 2'b00) begin
            errors++; $display("FAIL stop2_good: got %h %b expected c3 00", xd2, {xp2, xf2});
        end
        send(2, mkframe(9'h03C, 8, 1'b0, 1'b0, 2'b01), 11, BIT_NS);
        idle(20);
        checks++;
        if (xc2 !== c + 2) begin
            errors++; $display("FAIL stop2_count: got %0d expected 2", xc2 - c);
        end
        checks++;
        if (xd2 !== 8'h3C) begin
            errors++; $display("FAIL stop2_data: got %h expected 3c", xd2);
        end
        checks++;
        if ({xp2, xf2} !== 2'b01) begin
            errors++; $display("FAIL stop2_ferr: got %b expected 01", {xp2, xf2});
        end
    endtask

    task automatic test_glitch;
        int c, busy;
        c = xc2; busy = 0;
        @(posedge clk); #1;
        line[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        line[2] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b2) busy++;
        end
        checks++;
        if (busy < 1 || busy > 15) begin
            errors++; $display("FAIL glitch_busy_cycles: got %0d expected 1..15", busy);
        end
        checks++;
        if (xc2 !== c || v2 !== 1'b0) begin
            errors++; $display("FAIL glitch_valid: got %0d words valid %b expected 0 0", xc2 - c, v2);
        end
    endtask

    task automatic test_overrun;
        int s, c, oc;
        rdy[0] = 1'b0;
        c = xc0; oc = oc0;
        @(posedge clk); #1;
        send(0, mkframe(9'h011, 8, 1'b0, 1'b0, 2'b11), 10, BIT_NS);
        send(0, mkframe(9'h022, 8, 1'b0, 1'b0, 2'b11), 10, BIT_NS);
        idle(20);
        @(negedge clk);
        checks++;
        if (v0 !== 1'b1 || d0 !== 8'h11) begin
            errors++; $display("FAIL ovr_hold: got valid %b data %h expected 1 11", v0, d0);
        end
        checks++;
        if (oc0 - oc !== 1) begin
            errors++; $display("FAIL ovr_pulse: got %0d cycles expected 1", oc0 - oc);
        end
        checks++;
        if (xc0 !== c) begin
            errors++; $display("FAIL ovr_no_xfer: got %0d expected 0", xc0 - c);
        end
        @(posedge clk); #1;
        s = cyc;
        fork
            send(0, mkframe(9'h033, 8, 1'b0, 1'b0, 2'b11), 10, BIT_NS);
            begin
                wait_cyc(s + lat - 1);
                #1;
                rdy[0] = 1'b1;
                wait_cyc(s + lat);
                #1;
                rdy[0] = 1'b0;
                @(negedge clk);
                checks++;
                if (v0 !== 1'b1 || d0 !== 8'h33) begin
                    errors++; $display("FAIL same_cycle_load: got valid %b data %h expected 1 33", v0, d0);
                end
                checks++;
                if (xc0 !== c + 1 || xd0 !== 8'h11) begin
                    errors++; $display("FAIL same_cycle_xfer: got %0d words last %h expected 1 11", xc0 - c, xd0);
                end
            end
        join
        idle(10);
        rdy[0] = 1'b1;
        idle(3);
        checks++;
        if (xd0 !== 8'h33 || v0 !== 1'b0) begin
            errors++; $display("FAIL drain: got data %h valid %b expected 33 0", xd0, v0);
        end
    endtask

    task automatic test_reset_abort;
        int s, c, h;
        rdy[0] = 1'b1;
        c = xc0; h = vh0;
        @(posedge clk); #1;
        s = cyc;
        fork
            send(0, mkframe(9'h0F0, 8, 1'b0, 1'b0, 2'b11), 10, BIT_NS);
            begin
                wait_cyc(s + 16 * 5 + 8);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        idle(30);
        checks++;
        if (xc0 !== c || vh0 !== h) begin
            errors++; $display("FAIL abort_silent: got %0d words %0d valid cycles expected 0 0", xc0 - c, vh0 - h);
        end
        send(0, mkframe(9'h05A, 8, 1'b0, 1'b0, 2'b11), 10, BIT_NS);
        idle(20);
        checks++;
        if (xc0 !== c + 1 || xd0 !== 8'h5A || xf0 !== 1'b0) begin
            errors++; $display("FAIL abort_next: got %0d words data %h ferr %b expected 1 5a 0", xc0 - c, xd0, xf0);
        end
    endtask

    task automatic test_baud;
        int c;
        c = xc0;
        @(posedge clk); #1;
        send(0, mkframe(9'h05A, 8, 1'b0, 1'b0, 2'b11), 10, BIT_NS * 1.03);
        idle(20);
        checks++;
        if (xc0 !== c + 1 || xd0 !== 8'h5A || xf0 !== 1'b0) begin
            errors++; $display("FAIL baud_slow: got %0d words data %h ferr %b expected 1 5a 0", xc0 - c, xd0, xf0);
        end
        send(0, mkframe(9'h05A, 8, 1'b0, 1'b0, 2'b11), 10, BIT_NS * 0.97);
        idle(20);
        checks++;
        if (xc0 !== c + 2 || xd0 !== 8'h5A || xf0 !== 1'b0) begin
            errors++; $display("FAIL baud_fast: got %0d words data %h ferr %b expected 2 5a 0", xc0 - c, xd0, xf0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        line = 3'b111;
        rdy  = 3'b111;
        test_reset;
        test_8n1;
        test_parity;
        test_stop;
        test_glitch;
        test_overrun;
        test_reset_abort;
        test_baud;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver and successor to the fixed 8N1 receiver.
- Has its own oversampling baud generator, so no external bps start/flag pair is needed.
- Supports configurable data width, parity and stop bits, with majority-vote sampling, false-start rejection, error flags and a one-entry valid/ready output holding register.
- Sits between the board UART pin (CP2102 TX) and the command/data consumers in the top level.

Parameters:
- CLK_FREQ, 50000000: system clock in Hz.
- BAUD, 115200: line rate in bit/s.
- OVERSAMPLE, 16: samples per bit; even, range 8..32.
- DATA_BITS, 8: data bits per frame; range 5..9; LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- CLK_50M  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- UART_RX  in  1  asynchronous serial line; idles high.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- rx_data  out  DATA_BITS  received word.
- rx_valid  out  1  rx_data, parity_err and frame_err are valid; held until accepted.
- parity_err  out  1  parity mismatch for the held word.
- frame_err  out  1  a stop bit was sampled low for the held word.
- overrun_err  out  1  one-cycle pulse: a completed frame was dropped.
- rx_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset, taken on the CLK_50M edge while RST = 1:
  - All outputs go to 0.
  - The synchronizer and previous-sample register go to 1.
  - The state goes to IDLE and all counters clear.
  - Reset mid-frame abandons the frame. No rx_valid and no error flag is produced for it.
- Input path: UART_RX passes through a 2-FF synchronizer (rx_s). An edge register (rx_p) holds the previous rx_s.
- Tick generator:
  - DIV = round(CLK_FREQ / (BAUD × OVERSAMPLE)), with DIV ≥ 1. Constant elaboration check that DIV ≥ 1.
  - A free-running counter 0..DIV−1 emits a one-cycle tick on wrap.
  - The counter restarts at 0 on start-edge detection, which aligns sampling to the edge.
- Sample counter: scnt, 0..OVERSAMPLE−1, advances on tick.
- Sampling: bit value = majority of rx_s taken at scnt = OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is made at the third of these samples (the "centre point").
- State machine:
  - IDLE: when rx_p = 1 and rx_s = 0, clear scnt and go to START.
  - START: at the centre point, a majority of 1 is a false start; return to IDLE with no flags. A majority of 0 proceeds. At scnt wrap, go to DATA.
  - DATA: at each centre point, shift the voted bit into the MSB of a DATA_BITS shift register (LSB first on the line). A bit counter goes 0..DATA_BITS−1. After the last bit's wrap, go to PARITY if PARITY ≠ 0, else STOP.
  - PARITY: at the centre point, compare the voted bit with the XOR of the data bits. Odd parity expects XOR^1; even expects XOR. A mismatch sets perr_int. At wrap, go to STOP.
  - STOP: at each stop bit's centre point, a voted 0 sets ferr_int.
- Frame completion:
  - For the final stop bit, go to IDLE at its centre point, not at wrap, so back-to-back frames with minimum stop time are caught.
  - Completion at that centre point loads the holding register on the next clock: rx_valid = 1 one cycle after the centre point.
- Holding register handshake:
  - Transfer occurs in a cycle where rx_valid & rx_ready.
  - Transfer with no simultaneous completion: rx_valid goes to 0 next cycle; rx_data and the error flags hold their values.
  - Completion while rx_valid = 0, or in the same cycle as a transfer: load the new word and flags, and rx_valid stays or becomes 1.
  - Completion while rx_valid = 1 and rx_ready = 0: keep the old word, drop the new one, and pulse overrun_err for exactly 1 cycle.
- Error data handling:
  - Frames with frame_err or parity_err are still delivered with their flags set.
  - A frame_err frame whose line stays low (break) is received once. IDLE then needs a rising edge followed by a new falling edge before another start.

Decomposition:
- Package uart_pkg:
  - Parity encoding constants: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Function calc_div(clk, baud, os), shared with the matching transmitter.
- One sub-module, uart_baud_tick: divider with DIV parameter, sync restart input and tick output. It is reused by the transmitter.
- The frame FSM and holding register stay in uart_rx_param.

Test Plan:
- Bench parameters: CLK_FREQ = 1600000, BAUD = 100000, OVERSAMPLE = 16, so DIV = 1 and a bit is 16 clocks.
- 8N1, send 0xA5 with rx_ready = 1 → rx_valid high for 1 cycle, rx_data = 0xA5, both error flags 0. rx_valid rises 1 cycle after the stop-bit centre, 152 clocks after the start edge ±3 clocks of synchronizer/vote latency.
- PARITY = 2, DATA_BITS = 7, send 0x35 with correct even parity bit 0, then the same word with the parity bit forced 1 → first word parity_err = 0; second word rx_data = 0x35, parity_err = 1.
- STOP_BITS = 2, second stop bit driven low → frame_err = 1, data delivered. A 4-clock low glitch on an idle line → no rx_busy past START, no rx_valid.
- rx_ready = 0, send 0x11 then 0x22 back-to-back → rx_data stays 0x11, overrun_err pulses 1 cycle at the second completion. Then rx_ready = 1 with a third frame 0x33 completing in the same cycle → next rx_data = 0x33 and rx_valid stays 1.
- Assert RST for 1 cycle during bit 4 of a frame, then send 0x5A → no output for the aborted frame, 0x5A received correctly. Baud mismatch of ±3% on 0x5A, 8N1 → received correctly.
